bip_control_unit: RTL
=====================

// Module: bip_control_unit
// PURPOSE
//  Control unit for the BIP accumulator processor, driving the datapath's control interface.
//  Holds the PC and addresses program ROM. Decodes each 16-bit instruction into
//  sel_A/sel_B/op/w_acc plus RAM write enable and operand.
//  Sits between program ROM, datapath and data RAM; one instruction per FETCH/EXEC pair.
// PARAMETERS
//  PC_BITS    11  program-memory address width (PC, o_Addr_rom)
//  OPC_BITS    5  opcode field width, i_Instr[15:11]
//  D_BITS     11  operand field width, i_Instr[10:0]
//  S_BITS      2  sel_A width
//  CNT_BITS   16  executed-instruction counter width
// PORTS
//  i_clock      in   1         system clock, rising edge
//  i_reset      in   1         asynchronous, active-low reset
//  i_start      in   1         start/restart pulse (IDLE or HALT only)
//  i_Instr      in   16        ROM data; valid cycle after o_Addr_rom is driven
//  o_Addr_rom   out  PC_BITS   program-memory address (= PC)
//  o_Data       out  D_BITS    operand to datapath (i_Data) / RAM address
//  sel_A        out  S_BITS    ACC source: 00 RAM, 01 immediate, 10 ALU
//  sel_B        out  1         ALU B: 0 RAM, 1 immediate
//  i_op         out  1         ALU op: 0 add, 1 sub
//  w_acc        out  1         accumulator write enable
//  o_wr_ram     out  1         data RAM write enable (STO)
//  o_illegal    out  1         one-cycle pulse on undefined opcode
//  o_halted     out  1         high while in HALT
//  o_instr_cnt  out  CNT_BITS  instructions executed since start
// BEHAVIOUR
//  Reset: state IDLE, PC=0, o_instr_cnt=0; all enables, sel_*, i_op, o_Data = 0.
//  FSM: IDLE -i_start-> FETCH -> EXEC -> FETCH | HALT; HALT -i_start-> FETCH.
//   FETCH: o_Addr_rom=PC; all enables 0.
//   EXEC : i_Instr valid; decode; controls valid this cycle only; o_Data=i_Instr[10:0].
//   Opcodes: 00000 HLT, 00001 STO (wr_ram), 00010 LD (A=00), 00011 LDI (A=01),
//    00100 ADD (A=10,B=0,op=0), 00101 ADDI (B=1), 00110 SUB (op=1), 00111 SUBI (B=1,op=1).
//    Every op except HLT/STO asserts w_acc.
//   Non-HLT EXEC: PC<=PC+1 (wraps 2^PC_BITS-1 -> 0); cnt<=cnt+1 (wraps).
//   HLT: cnt<=cnt+1, PC held, next HALT; o_halted=1 from next cycle.
//  Illegal opcode (01000..11111): no enables; o_illegal=1 during EXEC; PC advances like NOP.
//  Restart (i_start in HALT): PC=0, cnt=0, go to FETCH. i_start ignored in FETCH/EXEC.
//  Data RAM is asynchronous-read; o_Data addresses it combinationally in EXEC.
//  Latency: 2 cycles/instruction; first control word 2 cycles after i_start sampled.
//  Reset mid-EXEC: all outputs drop to 0 immediately (async); no partial RAM write survives.
// CONFIGURATION
//  BIP_STEP_MODE_EN defined: adds input i_step and state WAIT_STEP. Non-HLT EXEC goes
//   to WAIT_STEP; leaves to FETCH on the cycle i_step=1. WAIT_STEP enables are 0.
//  Undefined: no i_step port, no WAIT_STEP; EXEC -> FETCH directly.
// STRUCTURE
//  bip_defs.vh: opcode localparams, sel_A encodings, FSM state encodings.
//  Sub-module bip_instr_decoder: combinational opcode -> {sel_A, sel_B, op, w_acc, wr_ram, illegal, hlt}.
//  Top: FSM, PC, counter, gating of decoder outputs to EXEC.
// TESTING
//  Reset low mid-run -> all outputs 0 same cycle; after release, state IDLE, o_Addr_rom=0.
//  ROM {LDI 3, ADD 1, STO 2, HLT}, pulse i_start -> EXEC words (A,B,op,w_acc,wr) =
//   (01,x,x,1,0), (10,0,0,1,0), (xx,x,x,0,1) with o_Data=2, then HLT; o_instr_cnt=4, PC=3.
//  Opcode 01010 at PC 0 -> o_illegal one cycle, no enables, PC=1 next FETCH.
//  PC preloaded at 2047 via NOP chain -> next FETCH o_Addr_rom=0.
//  In HALT pulse i_start -> PC=0, cnt=0, FETCH; i_start during EXEC -> ignored.
//  BIP_STEP_MODE_EN: after ADDI, PC holds 5 idle cycles until i_step=1, then FETCH.

Source files
------------

// File: rtl/bip_control_unit_pkg.sv
// Shared widths, opcode/sel_A encodings, FSM states and decoded control word
// for the BIP control unit. BIP_STEP_MODE_EN adds the WAIT_STEP state.
package bip_control_unit_pkg;

  localparam int unsigned PC_BITS    = 11;
  localparam int unsigned OPC_BITS   = 5;
  localparam int unsigned D_BITS     = 11;
  localparam int unsigned S_BITS     = 2;
  localparam int unsigned CNT_BITS   = 16;
  localparam int unsigned INSTR_BITS = OPC_BITS + D_BITS;

  typedef enum logic [OPC_BITS-1:0] {
    OPC_HLT  = 5'b00000,
    OPC_STO  = 5'b00001,
    OPC_LD   = 5'b00010,
    OPC_LDI  = 5'b00011,
    OPC_ADD  = 5'b00100,
    OPC_ADDI = 5'b00101,
    OPC_SUB  = 5'b00110,
    OPC_SUBI = 5'b00111
  } opcode_e;

  // Accumulator source select
  localparam logic [S_BITS-1:0] SEL_A_RAM = 2'b00;
  localparam logic [S_BITS-1:0] SEL_A_IMM = 2'b01;
  localparam logic [S_BITS-1:0] SEL_A_ALU = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_HALT      = 3'd3
`ifdef BIP_STEP_MODE_EN
    , ST_WAIT_STEP = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic [S_BITS-1:0] sel_a;
    logic              sel_b;
    logic              op;
    logic              w_acc;
    logic              wr_ram;
    logic              illegal;
    logic              hlt;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode decoder: maps the 5-bit opcode onto the datapath
// control word; anything outside the defined set is flagged illegal.
module bip_instr_decoder
  import bip_control_unit_pkg::*;
(
  input  logic [OPC_BITS-1:0] i_opcode,
  output ctrl_t               o_ctrl_c
);

  always_comb begin
    o_ctrl_c = CTRL_NONE;
    case (opcode_e'(i_opcode))
      OPC_HLT: begin
        o_ctrl_c.hlt = 1'b1;
      end
      OPC_STO: begin
        o_ctrl_c.wr_ram = 1'b1;
      end
      OPC_LD: begin
        o_ctrl_c.sel_a = SEL_A_RAM;
        o_ctrl_c.w_acc = 1'b1;
      end
      OPC_LDI: begin
        o_ctrl_c.sel_a = SEL_A_IMM;
        o_ctrl_c.w_acc = 1'b1;
      end
      OPC_ADD: begin
        o_ctrl_c.sel_a = SEL_A_ALU;
        o_ctrl_c.w_acc = 1'b1;
      end
      OPC_ADDI: begin
        o_ctrl_c.sel_a = SEL_A_ALU;
        o_ctrl_c.sel_b = 1'b1;
        o_ctrl_c.w_acc = 1'b1;
      end
      OPC_SUB: begin
        o_ctrl_c.sel_a = SEL_A_ALU;
        o_ctrl_c.op    = 1'b1;
        o_ctrl_c.w_acc = 1'b1;
      end
      OPC_SUBI: begin
        o_ctrl_c.sel_a = SEL_A_ALU;
        o_ctrl_c.sel_b = 1'b1;
        o_ctrl_c.op    = 1'b1;
        o_ctrl_c.w_acc = 1'b1;
      end
      default: begin
        o_ctrl_c.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: FETCH/EXEC sequencer, PC, executed-instruction counter and
// EXEC-gated control word. Define BIP_STEP_MODE_EN for single-step (i_step/WAIT_STEP).
module bip_control_unit
  import bip_control_unit_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
`ifdef BIP_STEP_MODE_EN
  input  logic                  i_step,
`endif
  input  logic [INSTR_BITS-1:0] i_Instr,
  output logic [PC_BITS-1:0]    o_Addr_rom,
  output logic [D_BITS-1:0]     o_Data,
  output logic [S_BITS-1:0]     sel_A,
  output logic                  sel_B,
  output logic                  i_op,
  output logic                  w_acc,
  output logic                  o_wr_ram,
  output logic                  o_illegal,
  output logic                  o_halted,
  output logic [CNT_BITS-1:0]   o_instr_cnt
);

  state_e                state_q, state_d;
  logic [PC_BITS-1:0]    pc_q, pc_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  ctrl_t                 dec_c;
  logic                  exec_c;

  bip_instr_decoder u_decoder (
    .i_opcode (i_Instr[INSTR_BITS-1 -: OPC_BITS]),
    .o_ctrl_c (dec_c)
  );

  assign exec_c = (state_q == ST_EXEC);

  // Sequencer: next state, PC and instruction count
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CNT_BITS'(1);
        if (dec_c.hlt) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + PC_BITS'(1);
`ifdef BIP_STEP_MODE_EN
          state_d = ST_WAIT_STEP;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef BIP_STEP_MODE_EN
      ST_WAIT_STEP: begin
        if (i_step) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control word is live only in EXEC, so an async reset clears it at once
  always_comb begin
    o_Data    = '0;
    sel_A     = '0;
    sel_B     = 1'b0;
    i_op      = 1'b0;
    w_acc     = 1'b0;
    o_wr_ram  = 1'b0;
    o_illegal = 1'b0;
    if (exec_c) begin
      o_Data    = i_Instr[D_BITS-1:0];
      sel_A     = dec_c.sel_a;
      sel_B     = dec_c.sel_b;
      i_op      = dec_c.op;
      w_acc     = dec_c.w_acc;
      o_wr_ram  = dec_c.wr_ram;
      o_illegal = dec_c.illegal;
    end
  end

  assign o_Addr_rom  = pc_q;
  assign o_instr_cnt = cnt_q;
  assign o_halted    = (state_q == ST_HALT);

endmodule
